// File: rtl/source_rand_pkt.sv
// Random packet source: LFSR-driven payload, packet length and idle gaps on a
// valid/ready stream, with a counting-data mode for deterministic traffic.
module source_rand_pkt #(
    parameter int          WIDTH     = 8,
    parameter int          PKT_LEN_W = 4,
    parameter int          GAP_W     = 3,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic [15:0]      pkt_cnt
);

    localparam logic [31:0]        SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [PKT_LEN_W:0] MAX_LEN  = (PKT_LEN_W + 1)'(1) << PKT_LEN_W;

    typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    state_t             state;
    logic [31:0]        lfsr;
    logic [WIDTH-1:0]   cnt_data;
    logic [1:0]         mode_q;
    logic [PKT_LEN_W:0] rem;
    logic [GAP_W-1:0]   gap_next;
    logic [GAP_W-1:0]   gap_cnt;

    logic               xfer;
    logic               is_start;
    logic               load;
    logic [1:0]         eff_mode;
    logic               counting;
    logic [31:0]        p_val;
    logic [31:0]        v_val;
    logic [PKT_LEN_W:0] rem_cur;
    logic [GAP_W-1:0]   gap_before;
    logic [GAP_W-1:0]   gap_after;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        xfer       = 1'b0;
        is_start   = 1'b0;
        load       = 1'b0;
        eff_mode   = mode_q;
        p_val      = lfsr_step(lfsr);
        v_val      = lfsr_step(lfsr);
        rem_cur    = rem;
        gap_before = gap_next;
        gap_after  = '0;

        xfer     = (state == SEND) && valid && ready;
        is_start = ((state == IDLE) && en) || (xfer && last && en);
        load     = is_start || (xfer && !last);

        // A packet start steps the LFSR twice: P for the packet fields, V for beat 1.
        if (is_start) begin
            eff_mode = mode;
            v_val    = lfsr_step(p_val);
            rem_cur  = mode[1] ? MAX_LEN : (PKT_LEN_W + 1)'(p_val[PKT_LEN_W-1:0]) + 1'b1;
            gap_before = mode[0] ? '0 : p_val[31 -: GAP_W];
        end
        counting  = (eff_mode == 2'b11);
        gap_after = eff_mode[0] ? '0 : v_val[31 -: GAP_W];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED_EFF;
            cnt_data <= '0;
            mode_q   <= '0;
            rem      <= '0;
            gap_next <= '0;
            gap_cnt  <= '0;
            valid    <= 1'b0;
            data     <= '0;
            last     <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            if (xfer && last)
                pkt_cnt <= pkt_cnt + 16'd1;

            if (load) begin
                if (is_start)
                    mode_q <= mode;
                if (counting) begin
                    data     <= cnt_data;
                    cnt_data <= cnt_data + 1'b1;
                end else begin
                    lfsr <= v_val;
                    data <= v_val[WIDTH-1:0];
                end
                last     <= (rem_cur == (PKT_LEN_W + 1)'(1));
                rem      <= rem_cur - 1'b1;
                gap_next <= gap_after;
                if (gap_before == '0) begin
                    state <= SEND;
                    valid <= 1'b1;
                end else begin
                    state   <= GAP;
                    valid   <= 1'b0;
                    gap_cnt <= gap_before;
                end
            end else if (xfer) begin
                // Last beat accepted with en low: packet finished, go quiet.
                state <= IDLE;
                valid <= 1'b0;
                last  <= 1'b0;
            end else if (state == GAP) begin
                if (gap_cnt == GAP_W'(1)) begin
                    state <= SEND;
                    valid <= 1'b1;
                end
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_source_rand_pkt.sv
// Directed bench for source_rand_pkt: reset, random-length/gap packets, stall,
// counting mode and en/mode changes mid-packet, against hand-computed values.
module tb_source_rand_pkt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        ready;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic [15:0] pkt_cnt;

    int tests = 0;
    int fails = 0;

    source_rand_pkt dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .ready   (ready),
        .valid   (valid),
        .data    (data),
        .last    (last),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [7:0] exp_data, input logic exp_last);
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " data"}, 32'(data), 32'(exp_data));
        check({tag, " last"}, 32'(last), 32'(exp_last));
    endtask

    initial begin
        // Reset state, before any clock edge
        rst = 1'b1; en = 1'b0; mode = 2'b01; ready = 1'b1;
        #2;
        check("rst valid", 32'(valid), 32'd0);
        check("rst data", 32'(data), 32'd0);
        check("rst last", 32'(last), 32'd0);
        check("rst pkt_cnt", 32'(pkt_cnt), 32'd0);
        tick(); tick();
        rst = 1'b0; en = 1'b1;

        // Mode 01: length 4 (P=0x80200003), data 02,01,03,02 back-to-back
        tick(); check_beat("m01 b1", 8'h02, 1'b0);
        tick(); check_beat("m01 b2", 8'h01, 1'b0);
        tick(); check_beat("m01 b3", 8'h03, 1'b0);
        tick(); check_beat("m01 b4", 8'h02, 1'b1);
        en = 1'b0;
        tick();
        check("m01 end valid", 32'(valid), 32'd0);
        check("m01 pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Async reset mid-packet, no clock edge
        en = 1'b1;
        tick();
        check("pre-rst valid", 32'(valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async valid", 32'(valid), 32'd0);
        check("async last", 32'(last), 32'd0);
        check("async data", 32'(data), 32'd0);
        check("async pkt_cnt", 32'(pkt_cnt), 32'd0);
        mode = 2'b00; en = 1'b0;
        tick(); tick();
        rst = 1'b0; en = 1'b1;

        // Mode 00: 4 idle cycles, beat 02, stall 20 cycles, then 6 idle cycles, beat 01
        tick(); check("m00 gap0", 32'(valid), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick(); check($sformatf("m00 gap%0d", i), 32'(valid), 32'd0);
        end
        tick(); check_beat("m00 b1", 8'h02, 1'b0);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); check_beat($sformatf("stall %0d", i), 8'h02, 1'b0);
        end
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); check($sformatf("m00 gapb%0d", i), 32'(valid), 32'd0);
        end
        tick(); check_beat("m00 b2", 8'h01, 1'b0);

        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; mode = 2'b11; en = 1'b1;

        // Mode 11: two 16-beat counting packets, no idle cycles
        tick();
        for (int i = 0; i < 32; i++) begin
            check_beat($sformatf("m11 b%0d", i), 8'(i), (i % 16) == 15);
            check($sformatf("m11 pkt_cnt%0d", i), 32'(pkt_cnt), (i >= 16) ? 32'd1 : 32'd0);
            if (i == 31) en = 1'b0;
            tick();
        end
        check("m11 end valid", 32'(valid), 32'd0);
        check("m11 pkt_cnt", 32'(pkt_cnt), 32'd2);

        // en dropped and mode changed on beat 2: packet completes unchanged
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 2'b01; en = 1'b1;
        tick(); check_beat("endrop b1", 8'h02, 1'b0);
        tick(); check_beat("endrop b2", 8'h01, 1'b0);
        en = 1'b0; mode = 2'b11;
        tick(); check_beat("endrop b3", 8'h03, 1'b0);
        tick(); check_beat("endrop b4", 8'h02, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("endrop idle valid%0d", i), 32'(valid), 32'd0);
            check($sformatf("endrop pkt_cnt%0d", i), 32'(pkt_cnt), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
